instruction_cache_controller: RTL and testbench

- Direct-mapped instruction cache between the CPU fetch stage and the 128-bit-block instruction memory.
- Serves 32-bit instruction fetches: hits return in 0 cycles; misses stall the CPU.
- On a miss it acts as the read initiator toward instruction memory: drives read and a 28-bit block address, waits out busywait, then captures the 128-bit block into the indexed line.

---
 rtl/instruction_cache_controller.sv | 130 +++++++++++++
 tb/tb_instruction_cache_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instruction_cache_controller.sv
// Direct-mapped, read-only instruction cache: 32-bit fetch port and 128-bit block refill port.
module instruction_cache_controller #(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_BITS   = 28 - INDEX_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic [31:0]  cpu_address,
    output logic [31:0]  cpu_readdata,
    output logic         cpu_busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int unsigned LINES   = 2 ** INDEX_BITS;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_start;
    logic                  w_fill;
    logic                  w_hit;

    logic                  r_valid [LINES];
    logic [TAG_BITS-1:0]   r_tag   [LINES];
    logic [BLOCK_W-1:0]    r_data  [LINES];
    logic                  r_mem_read;
    logic [27:0]           r_mem_address;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [1:0]            w_word;
    logic [BLOCK_W-1:0]    w_line;
    logic                  w_unused;

    // Address decomposition: [31:4+INDEX_BITS] tag, [4+INDEX_BITS-1:4] index, [3:2] word
    assign w_index  = cpu_address[4+INDEX_BITS-1:4];
    assign w_tag    = cpu_address[31:4+INDEX_BITS];
    assign w_word   = cpu_address[3:2];
    assign w_line   = r_data[w_index];
    assign w_unused = &{1'b0, cpu_address[1:0]};

    // Lookup only counts as a hit while idle, so a refill always holds the stall through UPDATE
    assign w_hit        = (r_state == IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign cpu_busywait = cpu_read && !w_hit;
    assign mem_read     = r_mem_read;
    assign mem_address  = r_mem_address;

    // Little-endian word select out of the indexed line
    always_comb begin
        cpu_readdata = w_line[WORD_W-1:0];
        case (w_word)
            2'd0:    cpu_readdata = w_line[WORD_W-1:0];
            2'd1:    cpu_readdata = w_line[2*WORD_W-1:WORD_W];
            2'd2:    cpu_readdata = w_line[3*WORD_W-1:2*WORD_W];
            default: cpu_readdata = w_line[4*WORD_W-1:3*WORD_W];
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; w_start launches a refill, w_fill marks the completion edge
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_read && !w_hit) begin
                    w_next_state = MEM_READ;
                    w_start      = 1'b1;
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    w_next_state = UPDATE;
                    w_fill       = 1'b1;
                end
            end
            UPDATE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Line storage and registered memory request; reset abandons any refill in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
            r_mem_read    <= 1'b0;
            r_mem_address <= '0;
        end else begin
            if (w_start) begin
                r_mem_read    <= 1'b1;
                r_mem_address <= cpu_address[31:4];
            end
            if (w_fill) begin
                r_valid[w_index] <= 1'b1;
                r_tag[w_index]   <= w_tag;
                r_data[w_index]  <= mem_readdata;
                r_mem_read       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed self-checking bench for instruction_cache_controller with a 5-busy-cycle memory model.
module tb_instruction_cache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic [31:0]  cpu_address;
    logic [31:0]  cpu_readdata;
    logic         cpu_busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int errors = 0;
    int mem_cnt = 0;

    localparam int MEM_BUSY = 5;

    instruction_cache_controller #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_address  (cpu_address),
        .cpu_readdata (cpu_readdata),
        .cpu_busywait (cpu_busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    // Block contents: block 0 is the program from the test plan, others are {A, addr[23:0], word}
    function automatic logic [127:0] block_of(input logic [27:0] a);
        logic [127:0] b;
        if (a == 28'h0) begin
            b = {32'h00000013, 32'h02060405, 32'h00050023, 32'h00040019};
        end else begin
            for (int w = 0; w < 4; w++) begin
                b[32*w +: 32] = {4'hA, a[23:0], 4'(w)};
            end
        end
        return b;
    endfunction

    // Memory model: busy for MEM_BUSY cycles after mem_read rises, then ready with the block
    always @(posedge clock) begin
        if (!mem_read) mem_cnt <= 0;
        else if (mem_cnt < MEM_BUSY) mem_cnt <= mem_cnt + 1;
    end
    assign mem_busywait = mem_read && (mem_cnt < MEM_BUSY);
    assign mem_readdata = block_of(mem_address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One fetch starting at the next falling edge; a miss is followed through refill to the hit
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic miss, input logic [27:0] exp_maddr);
        int busy_seen;
        bit done;
        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = addr;
        #1;
        check_eq("lookup_busywait", 32'(cpu_busywait), 32'(miss));
        check_eq("lookup_mem_read", 32'(mem_read), 32'h0);
        if (!miss) begin
            check_eq("hit_data", cpu_readdata, exp_data);
        end else begin
            @(negedge clock); #1;
            check_eq("req_mem_read", 32'(mem_read), 32'h1);
            check_eq("req_mem_address", 32'(mem_address), 32'(exp_maddr));
            busy_seen = 0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (mem_read && mem_busywait) busy_seen++;
                check_eq("stall_busywait", 32'(cpu_busywait), 32'h1);
                @(negedge clock); #1;
                if (!mem_read) done = 1'b1;
            end
            check_eq("refill_done", 32'(done), 32'h1);
            check_eq("busy_cycles", 32'(busy_seen), 32'(MEM_BUSY));
            check_eq("update_busywait", 32'(cpu_busywait), 32'h1);
            @(negedge clock); #1;
            check_eq("after_busywait", 32'(cpu_busywait), 32'h0);
            check_eq("after_data", cpu_readdata, exp_data);
            check_eq("after_mem_read", 32'(mem_read), 32'h0);
        end
    endtask

    // Address must stay stable while the CPU is stalled
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    always @(posedge clock) begin
        if (!reset && prev_stall)
            assert (cpu_address == prev_addr) else $error("cpu_address changed while stalled");
        prev_stall <= cpu_read && cpu_busywait;
        prev_addr  <= cpu_address;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        cpu_read    = 1'b0;
        cpu_address = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("reset_busywait", 32'(cpu_busywait), 32'h0);
        check_eq("reset_mem_read", 32'(mem_read), 32'h0);
        check_eq("reset_mem_address", 32'(mem_address), 32'h0);

        // Cold miss then hits on the rest of block 0
        fetch(32'h00000000, 32'h00040019, 1'b1, 28'h0000000);
        fetch(32'h00000004, 32'h00050023, 1'b0, 28'h0);
        fetch(32'h00000008, 32'h02060405, 1'b0, 28'h0);
        fetch(32'h0000000C, 32'h00000013, 1'b0, 28'h0);

        // Conflict on index 0 replaces the line; block 0 must then miss again
        fetch(32'h00000080, 32'hA0000080, 1'b1, 28'h0000008);
        fetch(32'h00000084, 32'hA0000081, 1'b0, 28'h0);
        fetch(32'h00000000, 32'h00040019, 1'b1, 28'h0000000);

        // Different index leaves line 0 untouched
        fetch(32'h00000010, 32'hA0000010, 1'b1, 28'h0000001);
        fetch(32'h0000001C, 32'hA0000013, 1'b0, 28'h0);
        fetch(32'h00000000, 32'h00040019, 1'b0, 28'h0);

        // Reset in the middle of a refill
        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_address = 32'h00000020;
        @(negedge clock); #1;
        check_eq("abort_req_mem_read", 32'(mem_read), 32'h1);
        check_eq("abort_req_address", 32'(mem_address), 32'h2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        cpu_read = 1'b0;
        #1;
        check_eq("abort_mem_read", 32'(mem_read), 32'h0);
        check_eq("abort_busywait", 32'(cpu_busywait), 32'h0);
        fetch(32'h00000020, 32'hA0000020, 1'b1, 28'h0000002);
        fetch(32'h00000000, 32'h00040019, 1'b1, 28'h0000000);

        // No request means no stall and no memory traffic
        @(negedge clock);
        cpu_read    = 1'b0;
        cpu_address = 32'hFFFFFFF0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_eq("idle_busywait", 32'(cpu_busywait), 32'h0);
            check_eq("idle_mem_read", 32'(mem_read), 32'h0);
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
